// File: rtl/lsu_mem_master_pkg.sv
// Shared definitions for the load/store memory master: funct3 and cause codes,
// access sizes, FSM encoding and the decode result bundle.
package lsu_mem_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] LT_NONE = 3'b000;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE    = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    typedef struct packed {
        logic [3:0] be;
        logic [2:0] load_type;
        logic       fault;
        logic [1:0] cause;
    } lsu_dec_t;

    // Offset of the last byte touched by an access of the given size.
    function automatic logic [1:0] last_byte_offset(input logic [1:0] size);
        case (size)
            SIZE_H:  return 2'd1;
            SIZE_W:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] size_byte_enable(input logic [1:0] size);
        case (size)
            SIZE_B:  return 4'b0001;
            SIZE_H:  return 4'b0011;
            SIZE_W:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request, response and data-memory signals of the load/store unit.
// master = the LSU itself; slave = execute/writeback plus the data memory.
interface lsu_mem_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [4:0]            req_rd;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [4:0]            rsp_rd;
    logic                  rsp_fault;
    logic [1:0]            rsp_cause;

    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [3:0]            mem_write_byte_enable;
    logic [2:0]            mem_load_type;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport master (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_rd, rsp_fault, rsp_cause,
        input  rsp_ready,
        output mem_wr_en, mem_rd_en, mem_write_byte_enable, mem_load_type,
        output mem_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_rd, rsp_fault, rsp_cause,
        output rsp_ready,
        input  mem_wr_en, mem_rd_en, mem_write_byte_enable, mem_load_type,
        input  mem_addr, mem_wr_data,
        output mem_rd_data
    );

endinterface

// File: rtl/lsu_mem_master_decode.sv
// Combinational request decode: funct3 + address -> byte enables, load type,
// masked store data and the highest-priority fault cause.
module lsu_mem_master_decode
    import lsu_mem_master_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int unsigned MEM_SIZE    = 1048576,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output lsu_dec_t              dec,
    output logic [DATA_WIDTH-1:0] wdata_masked
);

    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = AW1'(MEM_SIZE);

    logic [1:0]          size;
    logic                legal;
    logic                misaligned;
    logic                out_of_range;
    logic [ADDR_WIDTH:0] last_addr;
    logic [3:0]          size_be;

    always_comb begin
        size = funct3[1:0];

        if (is_store) begin
            legal = funct3 inside {F3_B, F3_H, F3_W};
        end else begin
            legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end

        misaligned = CHECK_ALIGN &&
                     ((size == SIZE_H && addr[0]) ||
                      (size == SIZE_W && addr[1:0] != 2'b00));

        // One extra bit keeps the end address from wrapping past the top of memory.
        last_addr    = {1'b0, addr} + AW1'(last_byte_offset(size));
        out_of_range = last_addr >= MEM_LIMIT;
        size_be      = size_byte_enable(size);

        dec = '0;
        if (!legal) begin
            dec.fault = 1'b1;
            dec.cause = CAUSE_ILLEGAL;
        end else if (misaligned) begin
            dec.fault = 1'b1;
            dec.cause = CAUSE_MISALIGN;
        end else if (out_of_range) begin
            dec.fault = 1'b1;
            dec.cause = CAUSE_RANGE;
        end else if (is_store) begin
            dec.be = size_be;
        end else begin
            dec.load_type = funct3;
        end

        wdata_masked = '0;
        for (int i = 0; i < 4; i++) begin
            if (dec.be[i]) begin
                wdata_masked[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/lsu_mem_master.sv
// CPU load/store unit, initiator side of the data-memory port: one request at a
// time through IDLE -> ACCESS -> RESP, with decode and fault checks at accept.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int unsigned MEM_SIZE    = 1048576,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    lsu_mem_master_if.master bus
);

    lsu_state_e            state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [2:0]            load_type_q, load_type_d;
    logic [4:0]            rd_q, rd_d;
    logic                  fault_q, fault_d;
    logic [1:0]            cause_q, cause_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    lsu_dec_t              dec;
    logic [DATA_WIDTH-1:0] dec_wdata;
    logic                  accept;
    logic                  access_live;

    lsu_mem_master_decode #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .MEM_SIZE    (MEM_SIZE),
        .CHECK_ALIGN (CHECK_ALIGN)
    ) u_decode (
        .is_store     (bus.req_is_store),
        .funct3       (bus.req_funct3),
        .addr         (bus.req_addr),
        .wdata        (bus.req_wdata),
        .dec          (dec),
        .wdata_masked (dec_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            is_store_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            load_type_q <= '0;
            rd_q        <= '0;
            fault_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            load_type_q <= load_type_d;
            rd_q        <= rd_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
            rdata_q     <= rdata_d;
        end
    end

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.req_valid) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request fields and decode are frozen at accept; only rdata moves afterwards.
    always_comb begin
        is_store_d  = is_store_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        load_type_d = load_type_q;
        rd_d        = rd_q;
        fault_d     = fault_q;
        cause_d     = cause_q;
        rdata_d     = rdata_q;
        if (accept) begin
            is_store_d  = bus.req_is_store;
            addr_d      = bus.req_addr;
            wdata_d     = dec_wdata;
            be_d        = dec.be;
            load_type_d = dec.load_type;
            rd_d        = bus.req_rd;
            fault_d     = dec.fault;
            cause_d     = dec.cause;
            rdata_d     = '0;
        end else if (state_q == ST_ACCESS && !is_store_q && !fault_q) begin
            rdata_d = bus.mem_rd_data;
        end
    end

    assign access_live = (state_q == ST_ACCESS) && !fault_q;

    // Memory outputs stay at zero except during a non-faulting ACCESS cycle.
    always_comb begin
        bus.req_ready             = (state_q == ST_IDLE);
        bus.rsp_valid             = (state_q == ST_RESP);
        bus.rsp_rdata             = rdata_q;
        bus.rsp_rd                = rd_q;
        bus.rsp_fault             = fault_q;
        bus.rsp_cause             = cause_q;
        bus.mem_wr_en             = 1'b0;
        bus.mem_rd_en             = 1'b0;
        bus.mem_write_byte_enable = '0;
        bus.mem_load_type         = LT_NONE;
        bus.mem_addr              = '0;
        bus.mem_wr_data           = '0;
        if (access_live) begin
            bus.mem_wr_en             = is_store_q;
            bus.mem_rd_en             = !is_store_q;
            bus.mem_write_byte_enable = be_q;
            bus.mem_load_type         = load_type_q;
            bus.mem_addr              = addr_q;
            bus.mem_wr_data           = wdata_q;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a byte-addressed data memory model
// that returns extended load data according to mem_load_type.
module tb_lsu_mem_master;

    localparam int unsigned MEM_SIZE = 1048576;

    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        flt;
        logic [1:0]  cause;
    } fvec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    lsu_mem_master #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_SIZE    (MEM_SIZE),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem_model [0:MEM_SIZE-1];
    int          wr_count = 0;
    int          rd_count = 0;
    logic [3:0]  cap_be    = '0;
    logic [31:0] cap_wdata = '0;
    logic [31:0] cap_addr  = '0;
    logic [19:0] rd_idx;
    logic [31:0] rd_word;

    // data_mem read port: combinational, byte select and extension by load type.
    always_comb begin
        rd_idx  = bus.mem_addr[19:0];
        rd_word = {mem_model[rd_idx + 20'd3], mem_model[rd_idx + 20'd2],
                   mem_model[rd_idx + 20'd1], mem_model[rd_idx]};
        case (bus.mem_load_type)
            3'b000:  bus.mem_rd_data = {{24{rd_word[7]}}, rd_word[7:0]};
            3'b001:  bus.mem_rd_data = {{16{rd_word[15]}}, rd_word[15:0]};
            3'b100:  bus.mem_rd_data = {24'h0, rd_word[7:0]};
            3'b101:  bus.mem_rd_data = {16'h0, rd_word[15:0]};
            default: bus.mem_rd_data = rd_word;
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_write_byte_enable[i])
                    mem_model[bus.mem_addr[19:0] + 20'(i)] <= bus.mem_wr_data[8*i +: 8];
            end
            wr_count  <= wr_count + 1;
            cap_be    <= bus.mem_write_byte_enable;
            cap_wdata <= bus.mem_wr_data;
            cap_addr  <= bus.mem_addr;
        end
        if (bus.mem_rd_en) rd_count <= rd_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one request in IDLE and returns clocks from presentation until rsp_valid.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd, output int lat);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0; bus.rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.mem_wr_en, bus.mem_rd_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_in: rsp_valid/wr/rd got %b%b%b expected 000",
                     bus.rsp_valid, bus.mem_wr_en, bus.mem_rd_en);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
        end
        n_checks++;
        if ({bus.rsp_rdata, bus.rsp_rd, bus.rsp_fault, bus.rsp_cause} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: rdata %h rd %0d fault %b cause %b expected all 0",
                     bus.rsp_rdata, bus.rsp_rd, bus.rsp_fault, bus.rsp_cause);
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wr_data, bus.mem_write_byte_enable, bus.mem_load_type} !== 71'h0) begin
            n_fail++;
            $display("FAIL reset_mem: addr %h wdata %h be %b lt %b expected all 0",
                     bus.mem_addr, bus.mem_wr_data, bus.mem_write_byte_enable, bus.mem_load_type);
        end
    endtask

    task automatic test_word();
        int lat; int w0; int r0;
        w0 = wr_count;
        run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3, lat);
        n_checks++;
        if (lat != 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        n_checks++;
        if (wr_count != w0 + 1 || cap_be !== 4'b1111 || cap_wdata !== 32'hDEADBEEF || cap_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL sw_write: writes %0d be %b data %h addr %h expected 1 1111 deadbeef 00000100",
                     wr_count - w0, cap_be, cap_wdata, cap_addr);
        end
        n_checks++;
        if ({bus.rsp_fault, bus.rsp_rdata, bus.rsp_rd} !== {1'b0, 32'h0, 5'd3}) begin
            n_fail++;
            $display("FAIL sw_rsp: fault %b rdata %h rd %0d expected 0 00000000 3",
                     bus.rsp_fault, bus.rsp_rdata, bus.rsp_rd);
        end
        n_checks++;
        if ({bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr} !== 34'h0) begin
            n_fail++;
            $display("FAIL resp_mem_idle: wr %b rd %b addr %h expected 0 0 0",
                     bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr);
        end
        finish_op();
        r0 = rd_count;
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd7, lat);
        n_checks++;
        if (lat != 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        n_checks++;
        if (bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_rd !== 5'd7 || rd_count != r0 + 1) begin
            n_fail++;
            $display("FAIL lw_rdata: rdata %h rd %0d reads %0d expected deadbeef 7 1",
                     bus.rsp_rdata, bus.rsp_rd, rd_count - r0);
        end
        finish_op();
    endtask

    task automatic test_byte_half();
        int lat;
        run_op(1'b1, 3'b000, 32'h203, 32'h12345680, 5'd1, lat);
        n_checks++;
        if (cap_be !== 4'b0001 || cap_wdata !== 32'h00000080 || cap_addr !== 32'h203) begin
            n_fail++;
            $display("FAIL sb_write: be %b data %h addr %h expected 0001 00000080 00000203",
                     cap_be, cap_wdata, cap_addr);
        end
        finish_op();
        run_op(1'b0, 3'b000, 32'h203, 32'h0, 5'd2, lat);
        n_checks++;
        if (bus.rsp_rdata !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL lb_sign: got %h expected ffffff80", bus.rsp_rdata);
        end
        finish_op();
        run_op(1'b0, 3'b100, 32'h203, 32'h0, 5'd2, lat);
        n_checks++;
        if (bus.rsp_rdata !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu_zero: got %h expected 00000080", bus.rsp_rdata);
        end
        finish_op();
        run_op(1'b1, 3'b001, 32'h300, 32'hABCD8001, 5'd1, lat);
        n_checks++;
        if (cap_be !== 4'b0011 || cap_wdata !== 32'h00008001) begin
            n_fail++;
            $display("FAIL sh_write: be %b data %h expected 0011 00008001", cap_be, cap_wdata);
        end
        finish_op();
        run_op(1'b0, 3'b001, 32'h300, 32'h0, 5'd5, lat);
        n_checks++;
        if (bus.rsp_rdata !== 32'hFFFF8001) begin
            n_fail++; $display("FAIL lh_sign: got %h expected ffff8001", bus.rsp_rdata);
        end
        finish_op();
        run_op(1'b0, 3'b101, 32'h300, 32'h0, 5'd5, lat);
        n_checks++;
        if (bus.rsp_rdata !== 32'h00008001) begin
            n_fail++; $display("FAIL lhu_zero: got %h expected 00008001", bus.rsp_rdata);
        end
        finish_op();
    endtask

    task automatic test_faults();
        fvec_t v [0:11];
        int lat; int w0; int r0; int exp_acc;
        v[0]  = '{1'b0, 3'b001, 32'h0000_0101, 1'b1, 2'b01};
        v[1]  = '{1'b1, 3'b010, 32'h000F_FFFE, 1'b1, 2'b01};
        v[2]  = '{1'b1, 3'b010, 32'h0010_0000, 1'b1, 2'b10};
        v[3]  = '{1'b0, 3'b011, 32'h0000_0100, 1'b1, 2'b11};
        v[4]  = '{1'b0, 3'b010, 32'hFFFF_FFFE, 1'b1, 2'b01};
        v[5]  = '{1'b0, 3'b010, 32'hFFFF_FFFC, 1'b1, 2'b10};
        v[6]  = '{1'b0, 3'b010, 32'h000F_FFFC, 1'b0, 2'b00};
        v[7]  = '{1'b0, 3'b000, 32'h000F_FFFF, 1'b0, 2'b00};
        v[8]  = '{1'b1, 3'b100, 32'h0000_0104, 1'b1, 2'b11};
        v[9]  = '{1'b0, 3'b111, 32'hFFFF_FFFF, 1'b1, 2'b11};
        v[10] = '{1'b0, 3'b101, 32'h0000_0102, 1'b0, 2'b00};
        v[11] = '{1'b0, 3'b001, 32'h000F_FFFF, 1'b1, 2'b01};
        for (int k = 0; k < 12; k++) begin
            w0 = wr_count;
            r0 = rd_count;
            run_op(v[k].st, v[k].f3, v[k].addr, 32'hA5A5A5A5, 5'(k + 1), lat);
            n_checks++;
            if ({bus.rsp_valid, bus.rsp_fault, bus.rsp_cause} !== {1'b1, v[k].flt, v[k].cause}) begin
                n_fail++;
                $display("FAIL fault_vec%0d: valid/fault/cause got %b/%b/%b expected 1/%b/%b",
                         k, bus.rsp_valid, bus.rsp_fault, bus.rsp_cause, v[k].flt, v[k].cause);
            end
            exp_acc = v[k].flt ? 0 : 1;
            n_checks++;
            if ((wr_count - w0) + (rd_count - r0) != exp_acc) begin
                n_fail++;
                $display("FAIL access_vec%0d: memory accesses %0d expected %0d",
                         k, (wr_count - w0) + (rd_count - r0), exp_acc);
            end
            if (v[k].flt) begin
                n_checks++;
                if (bus.rsp_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL rdata_vec%0d: got %h expected 00000000", k, bus.rsp_rdata);
                end
            end
            finish_op();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd9, lat);
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_addr     = 32'h203;
        bus.req_rd       = 5'd10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_rd, bus.req_ready} !== {1'b1, 32'hDEADBEEF, 5'd9, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: valid %b rdata %h rd %0d ready %b expected 1 deadbeef 9 0",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_rd, bus.req_ready);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_handshake: ready %b valid %b expected 1 0", bus.req_ready, bus.rsp_valid);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL next_accept: ready got %b expected 0", bus.req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_rd} !== {1'b1, 32'hFFFFFF80, 5'd10}) begin
            n_fail++;
            $display("FAIL next_rsp: valid %b rdata %h rd %0d expected 1 ffffff80 10",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_rd);
        end
        finish_op();
    endtask

    task automatic test_reset_mid_op();
        int lat; int w0;
        run_op(1'b1, 3'b010, 32'h400, 32'h11111111, 5'd4, lat);
        finish_op();
        w0 = wr_count;
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_funct3   = 3'b010;
        bus.req_addr     = 32'h400;
        bus.req_wdata    = 32'h55AA55AA;
        bus.req_rd       = 5'd4;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.mem_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL access_wr_en: got %b expected 1", bus.mem_wr_en);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_wr_en, bus.mem_write_byte_enable, bus.mem_addr, bus.mem_wr_data, bus.rsp_valid} !== 70'h0) begin
            n_fail++;
            $display("FAIL async_drop: wr %b be %b addr %h data %h valid %b expected all 0",
                     bus.mem_wr_en, bus.mem_write_byte_enable, bus.mem_addr, bus.mem_wr_data, bus.rsp_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (wr_count != w0) begin
            n_fail++; $display("FAIL no_commit: writes %0d expected 0", wr_count - w0);
        end
        n_checks++;
        if ({bus.req_ready, bus.rsp_rd, bus.rsp_fault, bus.rsp_rdata} !== {1'b1, 5'd0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL post_reset: ready %b rd %0d fault %b rdata %h expected 1 0 0 0",
                     bus.req_ready, bus.rsp_rd, bus.rsp_fault, bus.rsp_rdata);
        end
        run_op(1'b0, 3'b010, 32'h400, 32'h0, 5'd6, lat);
        n_checks++;
        if (bus.rsp_rdata !== 32'h11111111) begin
            n_fail++; $display("FAIL mem_unchanged: got %h expected 11111111", bus.rsp_rdata);
        end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_faults();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
